// File: rtl/unidade_controle_jogo.sv
// unidade_controle_jogo: control FSM for the sequence-checking game.
// Walks N_JOGADAS plays through the memory address counter, loads the play
// register on each play and finishes in fim_acerto, fim_erro or fim_timeout.
// Optional play timer: define UNIDADE_CONTROLE_JOGO_TIMEOUT_EN to compile it in;
// without it espera waits indefinitely and timeout stays 0.
module unidade_controle_jogo #(
    parameter int N_JOGADAS      = 16,
    parameter int ADDR_W         = 4,
    parameter int TIMEOUT_CICLOS = 3000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              jogada,
    input  logic              igual,
    output logic [ADDR_W-1:0] endereco,
    output logic              zeraR,
    output logic              registraR,
    output logic              pronto,
    output logic              acertou,
    output logic              errou,
    output logic              timeout,
    output logic [3:0]        db_estado
);

    // State codes double as the db_estado debug values.
    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARACAO  = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h4,
        COMPARACAO  = 4'h5,
        PROXIMO     = 4'h6,
        FIM_ACERTO  = 4'hA,
        FIM_TIMEOUT = 4'hD,
        FIM_ERRO    = 4'hE
    } estado_t;

    localparam logic [ADDR_W-1:0] ULTIMO = ADDR_W'(N_JOGADAS - 1);

    estado_t estado;
    logic    expirou;

`ifdef UNIDADE_CONTROLE_JOGO_TIMEOUT_EN
    localparam int                 TIMER_W   = $clog2(TIMEOUT_CICLOS);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CICLOS - 1);

    logic [TIMER_W-1:0] timer;

    assign expirou = (timer == TIMER_MAX);

    // Play timer: cleared before each espera, counts in espera, stops at expiry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else if (estado == PREPARACAO || estado == PROXIMO) begin
            timer <= '0;
        end else if (estado == ESPERA && !expirou) begin
            timer <= timer + TIMER_W'(1);
        end
    end
`else
    // Never true: without the timer espera only leaves on jogada.
    assign expirou = (TIMEOUT_CICLOS < 0);
`endif

    // Main FSM plus the play address counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado   <= INICIAL;
            endereco <= '0;
        end else begin
            case (estado)
                INICIAL: begin
                    if (iniciar) begin
                        estado   <= PREPARACAO;
                        endereco <= '0;
                    end
                end
                PREPARACAO: begin
                    endereco <= '0;
                    estado   <= ESPERA;
                end
                ESPERA: begin
                    // A play arriving on the expiry cycle still counts.
                    if (jogada) begin
                        estado <= REGISTRA;
                    end else if (expirou) begin
                        estado <= FIM_TIMEOUT;
                    end
                end
                REGISTRA: begin
                    estado <= COMPARACAO;
                end
                COMPARACAO: begin
                    if (!igual) begin
                        estado <= FIM_ERRO;
                    end else if (endereco == ULTIMO) begin
                        estado <= FIM_ACERTO;
                    end else begin
                        estado <= PROXIMO;
                    end
                end
                PROXIMO: begin
                    endereco <= endereco + ADDR_W'(1);
                    estado   <= ESPERA;
                end
                FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                    // endereco is held so the failing index stays visible.
                    if (iniciar) begin
                        estado   <= PREPARACAO;
                        endereco <= '0;
                    end
                end
                default: begin
                    estado <= INICIAL;
                end
            endcase
        end
    end

    // Moore output decode from the registered state.
    always_comb begin
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        db_estado = 4'hF;
        case (estado)
            INICIAL: begin
                zeraR     = 1'b1;
                db_estado = 4'h0;
            end
            PREPARACAO: begin
                zeraR     = 1'b1;
                db_estado = 4'h1;
            end
            ESPERA: begin
                db_estado = 4'h2;
            end
            REGISTRA: begin
                registraR = 1'b1;
                db_estado = 4'h4;
            end
            COMPARACAO: begin
                db_estado = 4'h5;
            end
            PROXIMO: begin
                db_estado = 4'h6;
            end
            FIM_ACERTO: begin
                pronto    = 1'b1;
                acertou   = 1'b1;
                db_estado = 4'hA;
            end
            FIM_ERRO: begin
                pronto    = 1'b1;
                errou     = 1'b1;
                db_estado = 4'hE;
            end
            FIM_TIMEOUT: begin
                pronto    = 1'b1;
                timeout   = 1'b1;
                db_estado = 4'hD;
            end
            default: begin
                db_estado = 4'hF;
            end
        endcase
    end

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Testbench for unidade_controle_jogo (N_JOGADAS=4, TIMEOUT_CICLOS=10).
// Expectations adapt to UNIDADE_CONTROLE_JOGO_TIMEOUT_EN being defined or not.
module tb_unidade_controle_jogo;

    localparam int N  = 4;
    localparam int AW = 4;
    localparam int TO = 10;
`ifdef UNIDADE_CONTROLE_JOGO_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clock   = 1'b0;
    logic          reset   = 1'b0;
    logic          iniciar = 1'b0;
    logic          jogada  = 1'b0;
    logic          igual   = 1'b0;
    logic [AW-1:0] endereco;
    logic          zeraR, registraR, pronto, acertou, errou, timeout;
    logic [3:0]    db_estado;

    unidade_controle_jogo #(
        .N_JOGADAS      (N),
        .ADDR_W         (AW),
        .TIMEOUT_CICLOS (TO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .jogada    (jogada),
        .igual     (igual),
        .endereco  (endereco),
        .zeraR     (zeraR),
        .registraR (registraR),
        .pronto    (pronto),
        .acertou   (acertou),
        .errou     (errou),
        .timeout   (timeout),
        .db_estado (db_estado)
    );

    // Clock and free-running cycle counter.
    always #5 clock = ~clock;

    int cyc_cnt = 0;
    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    // Expected round outcome.
    typedef struct packed {
        logic [31:0]   fim_ciclo;
        logic [7:0]    n_reg;
        logic [AW-1:0] endereco;
        logic          acertou;
        logic          errou;
        logic          tmo;
        logic [3:0]    estado;
    } resp_t;

    resp_t         exp_q[$];
    logic [AW-1:0] reg_q[$];

    int errors = 0;
    int checks = 0;

    int dl[N];
    bit ig[N];

    task automatic check(input string nome, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nome, act, req, $time);
        end
    endtask

    // Round outcome from the play list: per play a wait d in espera and the
    // comparator result. Edges counted from the edge that samples iniciar.
    function automatic resp_t modelo(input int d[N], input bit g[N], input int c0);
        resp_t r;
        int    t;
        r = '0;
        t = 1;
        for (int i = 0; i < N; i++) begin
            if (TO_EN && d[i] >= TO) begin
                t += TO;
                r.tmo = 1'b1;
                r.endereco = AW'(i);
                r.estado = 4'hD;
                break;
            end
            t += d[i] + 1;
            r.n_reg = r.n_reg + 8'd1;
            if (!g[i]) begin
                t += 2;
                r.errou = 1'b1;
                r.endereco = AW'(i);
                r.estado = 4'hE;
                break;
            end
            if (i == N - 1) begin
                t += 2;
                r.acertou = 1'b1;
                r.endereco = AW'(i);
                r.estado = 4'hA;
                break;
            end
            t += 3;
        end
        r.fim_ciclo = 32'(c0 + 1 + t);
        return r;
    endfunction

    function automatic logic ruido();
        return ($urandom_range(0, 3) == 0);
    endfunction

    // Drive inputs for the next rising edge.
    task automatic cyc(input logic ini, input logic jog);
        @(negedge clock);
        iniciar = ini;
        jogada  = jog;
    endtask

    task automatic run_round(input int d[N], input bit g[N]);
        resp_t r;
        bit    fim;
        cyc(1'b1, 1'b0);
        r = modelo(d, g, cyc_cnt);
        exp_q.push_back(r);
        @(posedge clock);
        #1;
        check("prep_estado", db_estado, 4'h1);
        check("prep_endereco", endereco, 0);
        check("prep_flags", {pronto, acertou, errou, timeout, zeraR}, 5'b00001);
        cyc(ruido(), 1'b0);
        fim = 1'b0;
        for (int i = 0; i < N && !fim; i++) begin
            if (TO_EN && d[i] >= TO) begin
                repeat (TO) begin
                    cyc(1'b0, 1'b0);
                    igual = 1'($urandom_range(0, 1));
                end
                fim = 1'b1;
            end else begin
                repeat (d[i]) begin
                    cyc(1'b0, 1'b0);
                    igual = 1'($urandom_range(0, 1));
                end
                cyc(1'b0, 1'b1);
                igual = g[i];
                reg_q.push_back(AW'(i));
                cyc(ruido(), ruido());
                cyc(ruido(), ruido());
                if (!g[i] || i == N - 1) fim = 1'b1;
                else cyc(ruido(), ruido());
            end
        end
        repeat (4) cyc(1'b0, ruido());
    endtask

    // Monitor: pops expectations when the DUT registers a play or finishes.
    task automatic monitor_loop();
        bit            prev_pronto;
        bit            holding;
        int            reg_cnt;
        resp_t         cur;
        logic [AW-1:0] e;
        prev_pronto = 1'b0;
        holding     = 1'b0;
        reg_cnt     = 0;
        cur         = '0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                prev_pronto = 1'b0;
                holding     = 1'b0;
                reg_cnt     = 0;
            end else begin
                if (registraR) begin
                    reg_cnt++;
                    if (reg_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL registra_inesperado: got registraR=1 at endereco=%0d, expected no pending play", endereco);
                    end else begin
                        e = reg_q.pop_front();
                        check("registra_endereco", endereco, e);
                        check("registra_estado", db_estado, 4'h4);
                    end
                end
                if (pronto && !prev_pronto) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL fim_inesperado: got pronto=1 db_estado=%0h, expected no round end", db_estado);
                        holding = 1'b0;
                    end else begin
                        cur = exp_q.pop_front();
                        check("fim_ciclo", cyc_cnt, cur.fim_ciclo);
                        check("fim_n_registra", reg_cnt, cur.n_reg);
                        holding = 1'b1;
                    end
                    reg_cnt = 0;
                end
                if (!pronto) holding = 1'b0;
                if (pronto && holding) begin
                    check("fim_flags", {acertou, errou, timeout}, {cur.acertou, cur.errou, cur.tmo});
                    check("fim_endereco", endereco, cur.endereco);
                    check("fim_estado", db_estado, cur.estado);
                end
                prev_pronto = pronto;
            end
        end
    endtask

    initial begin
        fork
            monitor_loop();
        join_none

        // Reset state.
        reset = 1'b0;
        #3;
        check("reset_estado", db_estado, 4'h0);
        check("reset_endereco", endereco, 0);
        check("reset_saidas", {zeraR, registraR, pronto, acertou, errou, timeout}, 6'b100000);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) cyc(1'b0, ruido());
        @(posedge clock);
        #1;
        check("inicial_ignora_jogada", db_estado, 4'h0);

        // Minimum-latency successful round.
        for (int i = 0; i < N; i++) begin dl[i] = 0; ig[i] = 1'b1; end
        run_round(dl, ig);

        // Wrong second play.
        for (int i = 0; i < N; i++) begin dl[i] = $urandom_range(0, 3); ig[i] = 1'b1; end
        ig[1] = 1'b0;
        run_round(dl, ig);

        // No play on the first espera: timeout, or a long idle wait without the timer.
        for (int i = 0; i < N; i++) begin dl[i] = 1; ig[i] = 1'b1; end
        dl[0] = TO_EN ? TO : 50;
        run_round(dl, ig);

        // Plays landing on the last timer cycle.
        dl[0] = TO - 1; dl[1] = 0; dl[2] = TO - 1; dl[3] = 2;
        for (int i = 0; i < N; i++) ig[i] = 1'b1;
        run_round(dl, ig);

        // Random rounds.
        for (int k = 0; k < 25; k++) begin
            for (int i = 0; i < N; i++) begin
                dl[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(TO, TO + 4) : $urandom_range(0, TO - 1);
                ig[i] = ($urandom_range(0, 9) != 0);
            end
            run_round(dl, ig);
        end

        // Reset asserted while in comparacao aborts the round.
        cyc(1'b1, 1'b0);
        @(posedge clock);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        igual = 1'b1;
        reg_q.push_back('0);
        @(posedge clock);
        #1;
        jogada = 1'b0;
        @(posedge clock);
        #1;
        check("aborto_comparacao", db_estado, 4'h5);
        #1;
        reset = 1'b0;
        #1;
        check("aborto_estado", db_estado, 4'h0);
        check("aborto_endereco", endereco, 0);
        check("aborto_saidas", {zeraR, registraR, pronto, acertou, errou, timeout}, 6'b100000);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) cyc(1'b0, 1'b0);
        @(posedge clock);
        #1;
        check("pos_aborto_estado", {pronto, db_estado}, 5'h00);

        // Recovery round after the abort.
        for (int i = 0; i < N; i++) begin dl[i] = $urandom_range(0, 4); ig[i] = 1'b1; end
        run_round(dl, ig);

        repeat (5) cyc(1'b0, 1'b0);
        check("fila_fim_vazia", exp_q.size(), 0);
        check("fila_registra_vazia", reg_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
